video_syncgen: RTL and testbench

- Video timing generator clocked by the 25 MHz pixel clock PCK from the pixel-clock generator. It is the consumer side of that clock.
- Produces HSYNC, VSYNC, display-enable and pixel coordinates for the pattern and character display blocks.
- Default timing is VGA 640x480 @ 60 Hz.
- Parameterised, so other resolutions can reuse it with a matching PCK.

---
 rtl/video_syncgen.sv | 121 ++++++++++++
 tb/tb_video_syncgen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/video_syncgen.sv
// Video timing generator: HSYNC/VSYNC/DE and pixel coordinates from PCK.
// Optional frame counter output enabled by SYNCGEN_FRMCNT_EN.
module video_syncgen #(
  parameter int HACT = 640,
  parameter int HFP  = 16,
  parameter int HSW  = 96,
  parameter int HBP  = 48,
  parameter int VACT = 480,
  parameter int VFP  = 10,
  parameter int VSW  = 2,
  parameter int VBP  = 33,
  parameter int CW   = 10
) (
  input  logic          PCK,
  input  logic          RST_N,
  input  logic          ENABLE,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DE,
  output logic          FRAME_START
`ifdef SYNCGEN_FRMCNT_EN
  ,
  output logic [7:0]    FRAME_CNT
`endif
);

  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;

  localparam logic [CW-1:0] HMAX   = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] VMAX   = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] HACT_C = CW'(HACT);
  localparam logic [CW-1:0] VACT_C = CW'(VACT);
  localparam logic [CW-1:0] HS_ON  = CW'(HACT + HFP);
  localparam logic [CW-1:0] HS_OFF = CW'(HACT + HFP + HSW - 1);
  localparam logic [CW-1:0] VS_ON  = CW'(VACT + VFP);
  localparam logic [CW-1:0] VS_OFF = CW'(VACT + VFP + VSW - 1);

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          fs_q, fs_d;

  // Outputs see hc/vc one edge late; PARK returns everything to reset values.
  always_comb begin
    hc_d    = '0;
    vc_d    = '0;
    hcnt_d  = '0;
    vcnt_d  = '0;
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    if (ENABLE) begin
      hcnt_d  = hc_q;
      vcnt_d  = vc_q;
      hsync_d = !(hc_q >= HS_ON && hc_q <= HS_OFF);
      vsync_d = !(vc_q >= VS_ON && vc_q <= VS_OFF);
      de_d    = (hc_q < HACT_C) && (vc_q < VACT_C);
      fs_d    = (hc_q == '0) && (vc_q == '0);
      if (hc_q == HMAX) begin
        hc_d = '0;
        vc_d = (vc_q == VMAX) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
        vc_d = vc_q;
      end
    end
  end

  always_ff @(posedge PCK or negedge RST_N) begin
    if (!RST_N) begin
      hc_q    <= '0;
      vc_q    <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign FRAME_START = fs_q;

`ifdef SYNCGEN_FRMCNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + (fs_d ? 8'd1 : 8'd0);
  end

  always_ff @(posedge PCK or negedge RST_N) begin
    if (!RST_N) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_syncgen.sv
// Bench for video_syncgen: default VGA instance plus a tiny-timing instance
// checked every cycle against a pixel-index model.
module tb_video_syncgen;

  localparam int SHA = 8, SHF = 2, SHW = 3, SHB = 3;
  localparam int SVA = 6, SVF = 2, SVW = 2, SVB = 2;
  localparam int SFR = (SHA + SHF + SHW + SHB) * (SVA + SVF + SVW + SVB);

  logic       PCK = 1'b0;
  logic       RST_N = 1'b0;
  logic       en_b = 1'b1;
  logic       en_s = 1'b1;

  logic [9:0] hc_b, vc_b;
  logic       hs_b, vs_b, de_b, fs_b;
  logic [4:0] hc_s, vc_s;
  logic       hs_s, vs_s, de_s, fs_s;
`ifdef SYNCGEN_FRMCNT_EN
  logic [7:0] fc_b, fc_s;
`endif

  int total = 0;
  int bad = 0;

  always #5 PCK = ~PCK;

  video_syncgen u_big (
    .PCK(PCK), .RST_N(RST_N), .ENABLE(en_b),
    .HCNT(hc_b), .VCNT(vc_b), .HSYNC(hs_b), .VSYNC(vs_b),
    .DE(de_b), .FRAME_START(fs_b)
`ifdef SYNCGEN_FRMCNT_EN
    , .FRAME_CNT(fc_b)
`endif
  );

  video_syncgen #(
    .HACT(SHA), .HFP(SHF), .HSW(SHW), .HBP(SHB),
    .VACT(SVA), .VFP(SVF), .VSW(SVW), .VBP(SVB), .CW(5)
  ) u_sm (
    .PCK(PCK), .RST_N(RST_N), .ENABLE(en_s),
    .HCNT(hc_s), .VCNT(vc_s), .HSYNC(hs_s), .VSYNC(vs_s),
    .DE(de_s), .FRAME_START(fs_s)
`ifdef SYNCGEN_FRMCNT_EN
    , .FRAME_CNT(fc_s)
`endif
  );

  typedef struct {
    int hc; int vc;
    bit hs; bit vs; bit de; bit fs;
  } exp_t;

  // k = number of consecutive enabled edges; output shows pixel index k-1.
  function automatic exp_t model(longint k, int ha, int hf, int hw, int hb,
                                 int va, int vf, int vw, int vb);
    exp_t e;
    int ht, vt;
    longint p;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    e = '{hc: 0, vc: 0, hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};
    if (k != 0) begin
      p = k - 1;
      e.hc = int'(p % ht);
      e.vc = int'((p / ht) % vt);
      e.hs = !(e.hc >= ha + hf && e.hc < ha + hf + hw);
      e.vs = !(e.vc >= va + vf && e.vc < va + vf + vw);
      e.de = (e.hc < ha) && (e.vc < va);
      e.fs = (e.hc == 0) && (e.vc == 0);
    end
    return e;
  endfunction

  longint     kb = 0, ks = 0;
  longint     fb_n = 0, fs_n = 0;
  logic [7:0] fcb_m = 0, fcs_m = 0;

  always @(posedge PCK or negedge RST_N) begin
    if (!RST_N) begin
      kb <= 0; ks <= 0; fcb_m <= 0; fcs_m <= 0;
    end else begin
      kb <= en_b ? kb + 1 : 0;
      ks <= en_s ? ks + 1 : 0;
      if (en_b && (kb % 420000) == 0) fcb_m <= fcb_m + 8'd1;
      if (en_s && (ks % SFR) == 0) fcs_m <= fcs_m + 8'd1;
    end
  end

  task automatic cmp(string nm, exp_t e, int hc, int vc,
                     bit hs, bit vs, bit de, bit fs);
    total++;
    if (e.hc != hc || e.vc != vc || e.hs != hs ||
        e.vs != vs || e.de != de || e.fs != fs) begin
      bad++;
      $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b fs=%b want h=%0d v=%0d hs=%b vs=%b de=%b fs=%b",
               nm, $time, hc, vc, hs, vs, de, fs,
               e.hc, e.vc, e.hs, e.vs, e.de, e.fs);
    end
  endtask

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, req);
    end
  endtask

  always @(negedge PCK) begin
    cmp("big", model(kb, 640, 16, 96, 48, 480, 10, 2, 33),
        int'(hc_b), int'(vc_b), hs_b, vs_b, de_b, fs_b);
    cmp("sm", model(ks, SHA, SHF, SHW, SHB, SVA, SVF, SVW, SVB),
        int'(hc_s), int'(vc_s), hs_s, vs_s, de_s, fs_s);
`ifdef SYNCGEN_FRMCNT_EN
    chk("fc_big", int'(fc_b), int'(fcb_m));
    chk("fc_sm", int'(fc_s), int'(fcs_m));
`endif
  end

  int de_cnt = 0;
  int fs_cnt = 0;

  initial begin
    repeat (5) @(negedge PCK);
    RST_N = 1'b1;
    @(negedge PCK);
    chk("first_hcnt", int'(hc_b), 0);
    chk("first_vcnt", int'(vc_b), 0);
    chk("first_de", int'(de_b), 1);
    chk("first_fs", int'(fs_b), 1);
    chk("first_fs_sm", int'(fs_s), 1);
    de_cnt = int'(de_b);
    @(negedge PCK);
    chk("second_fs", int'(fs_b), 0);
    chk("second_hcnt", int'(hc_b), 1);
    de_cnt += int'(de_b);
    for (int e = 3; e <= 805; e++) begin
      @(negedge PCK);
      if (e <= 800) de_cnt += int'(de_b);
      if (e == 656) chk("hs_before", int'(hs_b), 1);
      if (e == 657) begin
        chk("hs_fall_h", int'(hc_b), 656);
        chk("hs_fall", int'(hs_b), 0);
      end
      if (e == 752) chk("hs_last", int'(hs_b), 0);
      if (e == 753) begin
        chk("hs_rise_h", int'(hc_b), 752);
        chk("hs_rise", int'(hs_b), 1);
      end
      if (e == 800) chk("wrap_h799", int'(hc_b), 799);
      if (e == 801) begin
        chk("wrap_h0", int'(hc_b), 0);
        chk("wrap_v1", int'(vc_b), 1);
      end
    end
    chk("de_per_line", de_cnt, 640);

    en_s = 1'b0;
    @(negedge PCK);
    en_s = 1'b1;
    repeat (156) @(negedge PCK);
    chk("pre_drop_h", int'(hc_s), 11);
    chk("pre_drop_v", int'(vc_s), 9);
    chk("pre_drop_hs", int'(hs_s), 0);
    chk("pre_drop_vs", int'(vs_s), 0);
    en_s = 1'b0;
    @(negedge PCK);
    chk("drop_hs", int'(hs_s), 1);
    chk("drop_vs", int'(vs_s), 1);
    chk("drop_de", int'(de_s), 0);
    chk("drop_hv", int'(hc_s) + int'(vc_s), 0);
    repeat (9) @(negedge PCK);
    en_s = 1'b1;
    @(negedge PCK);
    chk("restart_fs", int'(fs_s), 1);
    chk("restart_hv", int'(hc_s) + int'(vc_s), 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge PCK);
      en_s = ($urandom_range(0, 99) < 96);
      en_b = ($urandom_range(0, 99) < 99);
    end

    en_s = 1'b1;
    en_b = 1'b1;
    repeat (50) @(negedge PCK);
    @(posedge PCK);
    #2 RST_N = 1'b0;
    #1;
    chk("async_hcnt", int'(hc_s) + int'(hc_b), 0);
    chk("async_vcnt", int'(vc_s) + int'(vc_b), 0);
    chk("async_sync", int'(hs_s & vs_s & hs_b & vs_b), 1);
    chk("async_de", int'(de_s | de_b | fs_s | fs_b), 0);
    @(negedge PCK);
    RST_N = 1'b1;

    for (int i = 0; i < 256 * SFR + 1; i++) begin
      @(negedge PCK);
      fs_cnt += int'(fs_s);
    end
    chk("fs_257", fs_cnt, 257);
`ifdef SYNCGEN_FRMCNT_EN
    chk("fc_wrap", int'(fc_s), 1);
    en_s = 1'b0;
    repeat (5) @(negedge PCK);
    chk("fc_hold", int'(fc_s), 1);
    en_s = 1'b1;
    @(negedge PCK);
    chk("fc_resume", int'(fc_s), 2);
`endif
    repeat (3) @(negedge PCK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
